piscaleds1: RTL and testbench
=============================

// Module: piscaleds1
// PURPOSE
//  - Pipelined triangle-area engine: three 11-bit unsigned vertices in, unsigned area out.
//  - Computes the shoelace determinant, takes its magnitude and halves it.
//  - Sits between the coordinate source (switch/sensor logic) and display/LED drivers on CLOCK_50.
// PARAMETERS
//  - CW   11  coordinate width (unsigned); all widths below derive from it
//  - AW   21  area output width = 2*CW-1
// PORTS
//  - CLOCK_50   in   1   system clock; all logic on its rising edge
//  - rst_n      in   1   synchronous reset, active low
//  - in_valid   in   1   coordinate set valid this cycle
//  - ax,ay      in   CW  vertex A x/y, unsigned, bit index 0 = MSB
//  - bx,by      in   CW  vertex B x/y, unsigned, bit index 0 = MSB
//  - cx,cy      in   CW  vertex C x/y, unsigned, bit index 0 = MSB
//  - out_valid  out  1   area holds a new result this cycle
//  - area       out  AW  floor(|det|/2), bit index 0 = MSB
// BEHAVIOUR
//  - Interface: one clock (CLOCK_50); reset rst_n is synchronous and active-low.
//  - det = ax*by + ay*cx + bx*cy - ay*bx - ax*cy - by*cx (twice the signed area).
//    - Signed, 2*CW+2 = 24 bits wide; no intermediate overflow allowed.
//    - Equivalent form (bx-ax)*(cy-ay) - (cx-ax)*(by-ay) is permitted.
//  - Pipeline, fixed 3-cycle latency, full throughput (one set per cycle, no stall):
//    - S1: register the signed differences/products.
//    - S2: register det.
//    - S3: register area = |det| >> 1 (floor) and out_valid.
//  - out_valid = in_valid delayed by exactly 3 cycles.
//  - area updates only when the S3 valid bit is 1; otherwise it holds its last value.
//  - Inputs are sampled only when in_valid=1; data with in_valid=0 never reaches area.
//  - Reset (synchronous, rst_n=0 at a clock edge):
//    - All pipeline valid bits, out_valid and area go to 0.
//    - In-flight sets are discarded, even mid-pipeline.
//    - First valid result appears 3 cycles after the first in_valid following release.
//  - Boundaries:
//    - Collinear or coincident vertices -> area=0.
//    - Odd |det| truncates (det=1 -> area=0).
//    - Max |det| = (2^CW-1)^2 = 4190209 -> area=2095104, fits AW with no saturation.
//    - Vertex order or winding never changes area.
// CONFIGURATION
//  - Macro PISCALEDS1_ORIENT_EN:
//    - Defined: adds output orient [1:0], aligned with area and out_valid.
//      - 2'b01 = CCW (det>0), 2'b10 = CW (det<0), 2'b00 = collinear (det=0).
//      - Reset value 2'b00; holds like area.
//    - Undefined: port and logic absent; area behaviour identical.
// STRUCTURE
//  - Package piscaleds1_pkg:
//    - CW, AW, DW=2*CW+2 constants.
//    - typedefs coord_t, det_t (signed DW), area_t.
//    - ORIENT_* localparams.
//  - One sub-module: tri_det (pipeline S1+S2: six coords -> registered signed det + valid).
//  - Top adds S3: abs, shift, orientation.
// TESTING
//  - Reset: hold rst_n=0 over 2 valid sets -> out_valid=0 and area=0 throughout;
//    after release, first result exactly 3 cycles after first in_valid.
//  - A=(1,82) B=(47,1) C=(47,165) -> det=7544, area=3772 (orient=CCW).
//    Swap B and C -> area=3772 (orient=CW).
//  - A=(1,5) B=(15,25) C=(3,50) -> area=295.
//    A=(0,0) B=(1,0) C=(0,1) -> area=0 (truncation).
//  - Collinear A=(0,0) B=(1,1) C=(2,2) -> area=0.
//    Max A=(0,0) B=(2047,0) C=(0,2047) -> area=2095104.
//  - Back-to-back: 4 sets on consecutive cycles -> 4 consecutive out_valid pulses, in order;
//    in_valid=0 gap -> out_valid=0 gap and area held.
//  - Mid-pipeline reset: assert rst_n=0 one cycle after in_valid -> that result never appears.

Source files
------------

// File: rtl/piscaleds1_pkg.sv
// Shared widths, types and orientation codes for the piscaleds1 triangle-area engine.
// Optional orientation output is enabled by defining PISCALEDS1_ORIENT_EN.
package piscaleds1_pkg;
  localparam int CW = 11;
  localparam int AW = 2*CW-1;
  localparam int DW = 2*CW+2;

  typedef logic        [0:CW-1] coord_t;
  typedef logic        [0:AW-1] area_t;
  typedef logic signed [DW-1:0] det_t;
  typedef logic signed [CW:0]   diff_t;

  localparam logic [1:0] ORIENT_COL = 2'b00;
  localparam logic [1:0] ORIENT_CCW = 2'b01;
  localparam logic [1:0] ORIENT_CW  = 2'b10;

  // Unsigned coordinates widened by one bit so the difference is exact and signed.
  function automatic diff_t sub_u(input coord_t a, input coord_t b);
    return diff_t'({1'b0, a}) - diff_t'({1'b0, b});
  endfunction
endpackage

// File: rtl/piscaleds1_tri_det.sv
// Stages S1+S2: cross-product terms, then the registered signed determinant.
module tri_det
  import piscaleds1_pkg::*;
(
  input  logic   CLOCK_50,
  input  logic   rst_n,
  input  logic   in_valid,
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t bx,
  input  coord_t by,
  input  coord_t cx,
  input  coord_t cy,
  output logic   det_valid,
  output det_t   det
);
  det_t       p1_d, p1_q, p2_d, p2_q, det_d, det_q;
  logic [1:0] vld_pipe_d, vld_pipe_q;

  // (b-a)x(c-a) form: products fit in 23 bits signed, difference in 24.
  always_comb begin
    p1_d       = p1_q;
    p2_d       = p2_q;
    det_d      = det_q;
    vld_pipe_d = {vld_pipe_q[0], in_valid};
    if (in_valid) begin
      p1_d = det_t'(sub_u(bx, ax)) * det_t'(sub_u(cy, ay));
      p2_d = det_t'(sub_u(cx, ax)) * det_t'(sub_u(by, ay));
    end
    if (vld_pipe_q[0])
      det_d = p1_q - p2_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      p1_q       <= '0;
      p2_q       <= '0;
      det_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      det_q      <= det_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign det_valid = vld_pipe_q[1];
  assign det       = det_q;
endmodule

// File: rtl/piscaleds1.sv
// Pipelined triangle area: floor(|det|/2) with fixed 3-cycle latency.
// Define PISCALEDS1_ORIENT_EN to add the winding-direction output 'orient'.
module piscaleds1
  import piscaleds1_pkg::*;
(
  input  logic   CLOCK_50,
  input  logic   rst_n,
  input  logic   in_valid,
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t bx,
  input  coord_t by,
  input  coord_t cx,
  input  coord_t cy,
  output logic   out_valid,
  output area_t  area
`ifdef PISCALEDS1_ORIENT_EN
  ,
  output logic [1:0] orient
`endif
);
  logic  det_valid;
  det_t  det, mag;
  logic  out_valid_d, out_valid_q;
  area_t area_d, area_q;

  tri_det u_tri_det (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ax        (ax),
    .ay        (ay),
    .bx        (bx),
    .by        (by),
    .cx        (cx),
    .cy        (cy),
    .det_valid (det_valid),
    .det       (det)
  );

  // |det| never exceeds (2^CW-1)^2, so negation cannot overflow.
  always_comb begin
    mag         = det[DW-1] ? -det : det;
    out_valid_d = det_valid;
    area_d      = area_q;
    if (det_valid)
      area_d = area_t'(mag >> 1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      area_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      area_q      <= area_d;
    end
  end

  assign out_valid = out_valid_q;
  assign area      = area_q;

`ifdef PISCALEDS1_ORIENT_EN
  logic [1:0] orient_d, orient_q;

  always_comb begin
    orient_d = orient_q;
    if (det_valid) begin
      if (det[DW-1])      orient_d = ORIENT_CW;
      else if (det != '0) orient_d = ORIENT_CCW;
      else                orient_d = ORIENT_COL;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) orient_q <= ORIENT_COL;
    else        orient_q <= orient_d;
  end

  assign orient = orient_q;
`endif
endmodule

// File: tb/tb_piscaleds1.sv
// Scoreboard bench for piscaleds1: expected area/orientation/arrival cycle queued at drive time.
module tb_piscaleds1;
  import piscaleds1_pkg::*;

  logic   CLOCK_50 = 1'b0;
  logic   rst_n    = 1'b0;
  logic   in_valid = 1'b0;
  coord_t ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
  logic   out_valid;
  area_t  area;
`ifdef PISCALEDS1_ORIENT_EN
  logic [1:0] orient;
`endif

  piscaleds1 dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ax        (ax),
    .ay        (ay),
    .bx        (bx),
    .by        (by),
    .cx        (cx),
    .cy        (cy),
    .out_valid (out_valid),
    .area      (area)
`ifdef PISCALEDS1_ORIENT_EN
    ,
    .orient    (orient)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int area;
    int orient;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model uses the six-term shoelace form directly.
  task automatic send(input int pax, pay, pbx, pby, pcx, pcy, input bit push);
    int   det, mag;
    exp_t e;
    @(negedge CLOCK_50);
    ax = coord_t'(pax); ay = coord_t'(pay);
    bx = coord_t'(pbx); by = coord_t'(pby);
    cx = coord_t'(pcx); cy = coord_t'(pcy);
    in_valid = 1'b1;
    if (push) begin
      det = pax*pby + pay*pcx + pbx*pcy - pay*pbx - pax*pcy - pby*pcx;
      mag = (det < 0) ? -det : det;
      e.area   = mag / 2;
      e.orient = (det > 0) ? 1 : (det < 0) ? 2 : 0;
      e.due    = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    ax = coord_t'($urandom); ay = coord_t'($urandom);
    bx = coord_t'($urandom); by = coord_t'($urandom);
    cx = coord_t'($urandom); cy = coord_t'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    chk("drain_left", q.size(), 0);
  endtask

  always @(negedge CLOCK_50) begin
    exp_t e;
    if (rst_n && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("area", int'(area), e.area);
        chk("latency", cyc, e.due);
`ifdef PISCALEDS1_ORIENT_EN
        chk("orient", int'(orient), e.orient);
`endif
      end
    end
  end

  initial begin
    int held;
    // Reset held over two valid sets.
    @(negedge CLOCK_50);
    send(1, 82, 47, 1, 47, 165, 1'b0);
    chk("rst_ov", out_valid, 0);
    chk("rst_area", int'(area), 0);
    send(2047, 0, 0, 2047, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("rst_ov", out_valid, 0);
      chk("rst_area", int'(area), 0);
`ifdef PISCALEDS1_ORIENT_EN
      chk("rst_orient", int'(orient), 0);
`endif
    end
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    idle();

    // Directed vectors.
    send(1, 82, 47, 1, 47, 165, 1'b1);
    idle(); idle(); idle(); idle();
    send(1, 82, 47, 165, 47, 1, 1'b1);
    send(1, 5, 15, 25, 3, 50, 1'b1);
    send(0, 0, 1, 0, 0, 1, 1'b1);
    idle();
    send(0, 0, 1, 1, 2, 2, 1'b1);
    send(5, 5, 5, 5, 5, 5, 1'b1);
    send(0, 0, 2047, 0, 0, 2047, 1'b1);
    send(2047, 2047, 0, 2047, 2047, 0, 1'b1);
    drain();

    // Back-to-back then a gap: area must hold while out_valid is low.
    send(1, 82, 47, 1, 47, 165, 1'b1);
    send(1, 5, 15, 25, 3, 50, 1'b1);
    send(0, 0, 2047, 0, 0, 2047, 1'b1);
    send(10, 20, 300, 40, 55, 900, 1'b1);
    idle(); idle(); idle(); idle();
    chk("b2b_drained", q.size(), 0);
    held = int'(area);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("gap_ov", out_valid, 0);
      chk("gap_hold", int'(area), held);
    end

    // Random sets with random gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      send($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
           $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b1);
    end
    drain();

    // Reset one cycle after in_valid: that set must never emerge.
    send(0, 0, 2047, 0, 0, 2047, 1'b0);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    chk("mid_rst_area", int'(area), 0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("mid_rst_ov", out_valid, 0);
    end

    // First result after release still arrives on time.
    send(1, 5, 15, 25, 3, 50, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", n_chk);
    $fatal(1);
  end
endmodule
